// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if
//   Bundles the three buses around the data-memory arbiter:
//     cpu_*  : MEM-stage access (ops, sign, address, data) plus the read data and stall back to it
//     ext_*  : external word requester (req/we/addr/wdata in; gnt/rdata/rvalid out)
//     mem_*  : data-memory port (ops, sign, address, write data out; combinational read data in)
//   Op encoding on every 2-bit op: 00 word, 01 half, 11 byte, 10 none.
//   slave  : arbiter side.
//   master : environment side (pipeline, requester and memory).
interface dmem_arbiter_if;
  logic [1:0]  cpu_rd_op;
  logic [1:0]  cpu_wr_op;
  logic        cpu_rd_sign;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [31:0] cpu_rdata;
  logic        cpu_stall;
  logic        ext_req;
  logic        ext_we;
  logic [31:0] ext_addr;
  logic [31:0] ext_wdata;
  logic        ext_gnt;
  logic [31:0] ext_rdata;
  logic        ext_rvalid;
  logic [1:0]  mem_rd_op;
  logic [1:0]  mem_wr_op;
  logic        mem_rd_sign;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  modport slave (
    input  cpu_rd_op, cpu_wr_op, cpu_rd_sign, cpu_addr, cpu_wdata,
    output cpu_rdata, cpu_stall,
    input  ext_req, ext_we, ext_addr, ext_wdata,
    output ext_gnt, ext_rdata, ext_rvalid,
    output mem_rd_op, mem_wr_op, mem_rd_sign, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output cpu_rd_op, cpu_wr_op, cpu_rd_sign, cpu_addr, cpu_wdata,
    input  cpu_rdata, cpu_stall,
    output ext_req, ext_we, ext_addr, ext_wdata,
    input  ext_gnt, ext_rdata, ext_rvalid,
    input  mem_rd_op, mem_wr_op, mem_rd_sign, mem_addr, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/dmem_arbiter.sv
// dmem_arbiter
//   Shares one data-memory port between the MEM stage (priority) and an
//   external word requester. A contention counter forces an external grant,
//   stalling the pipeline for one cycle, after MAX_WAIT lost cycles.
// Ports:
//   clk   : rising-edge clock
//   reset : synchronous, active-low
//   bus   : dmem_arbiter_if.slave (cpu_*, ext_*, mem_* buses)
// Parameters:
//   MAX_WAIT : contended cycles an external request may lose (1..15)
module dmem_arbiter #(
  parameter int MAX_WAIT = 4
) (
  input  logic           clk,
  input  logic           reset,
  dmem_arbiter_if.slave  bus
);

  localparam logic [1:0] OP_WORD = 2'b00;
  localparam logic [1:0] OP_NONE = 2'b10;
  localparam logic [3:0] WAIT_LAST = 4'(MAX_WAIT - 1);

  typedef enum logic {NORMAL, FORCE} state_e;

  state_e      state_q, state_d;
  logic [3:0]  wait_cnt_q, wait_cnt_d;
  logic [31:0] ext_rdata_q, ext_rdata_d;
  logic        ext_rvalid_q, ext_rvalid_d;

  logic cpu_active, cpu_own, ext_own, stall;

  always_comb begin
    state_d      = state_q;
    wait_cnt_d   = wait_cnt_q;
    cpu_own      = 1'b0;
    ext_own      = 1'b0;
    stall        = 1'b0;
    cpu_active   = (bus.cpu_rd_op != OP_NONE) || (bus.cpu_wr_op != OP_NONE);

    // While in reset nobody owns the port, so no op reaches memory.
    if (reset) begin
      unique case (state_q)
        NORMAL: begin
          if (bus.ext_req && !cpu_active) begin
            ext_own    = 1'b1;
            wait_cnt_d = '0;
          end else if (bus.ext_req) begin
            cpu_own = 1'b1;
            // Last tolerated loss: hold the count and force next cycle.
            if (wait_cnt_q == WAIT_LAST) state_d = FORCE;
            else                         wait_cnt_d = wait_cnt_q + 4'd1;
          end else begin
            cpu_own    = cpu_active;
            wait_cnt_d = '0;
          end
        end
        FORCE: begin
          // A withdrawn request simply gives the slot back to the CPU.
          if (bus.ext_req) begin
            ext_own = 1'b1;
            stall   = cpu_active;
          end else begin
            cpu_own = cpu_active;
          end
          state_d    = NORMAL;
          wait_cnt_d = '0;
        end
        default: state_d = NORMAL;
      endcase
    end

    ext_rdata_d  = ext_rdata_q;
    ext_rvalid_d = ext_own && !bus.ext_we;
    if (ext_own && !bus.ext_we) ext_rdata_d = bus.mem_rdata;
  end

  // Memory port mux.
  always_comb begin
    bus.mem_rd_op   = OP_NONE;
    bus.mem_wr_op   = OP_NONE;
    bus.mem_rd_sign = 1'b0;
    bus.mem_addr    = '0;
    bus.mem_wdata   = '0;
    if (ext_own) begin
      bus.mem_rd_op = bus.ext_we ? OP_NONE : OP_WORD;
      bus.mem_wr_op = bus.ext_we ? OP_WORD : OP_NONE;
      bus.mem_addr  = {bus.ext_addr[31:2], 2'b00};
      bus.mem_wdata = bus.ext_wdata;
    end else if (cpu_own) begin
      bus.mem_rd_op   = bus.cpu_rd_op;
      bus.mem_wr_op   = bus.cpu_wr_op;
      bus.mem_rd_sign = bus.cpu_rd_sign;
      bus.mem_addr    = bus.cpu_addr;
      bus.mem_wdata   = bus.cpu_wdata;
    end
  end

  assign bus.cpu_rdata  = cpu_own ? bus.mem_rdata : '0;
  assign bus.cpu_stall  = stall;
  assign bus.ext_gnt    = ext_own;
  assign bus.ext_rdata  = ext_rdata_q;
  assign bus.ext_rvalid = ext_rvalid_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= NORMAL;
      wait_cnt_q   <= '0;
      ext_rdata_q  <= '0;
      ext_rvalid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      wait_cnt_q   <= wait_cnt_d;
      ext_rdata_q  <= ext_rdata_d;
      ext_rvalid_q <= ext_rvalid_d;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter
//   Directed scenarios plus a randomized run against a behavioural model of
//   the arbitration rules (CPU first, external forced after MW lost cycles).
module tb_dmem_arbiter;
  localparam int MW = 4;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   failures = 0;

  dmem_arbiter_if bus();

  dmem_arbiter #(.MAX_WAIT(MW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    bus.cpu_rd_op   = 2'b10;
    bus.cpu_wr_op   = 2'b10;
    bus.cpu_rd_sign = 1'b0;
    bus.cpu_addr    = '0;
    bus.cpu_wdata   = '0;
    bus.ext_req     = 1'b0;
    bus.ext_we      = 1'b0;
    bus.ext_addr    = '0;
    bus.ext_wdata   = '0;
    bus.mem_rdata   = '0;
  endtask

  task automatic test_reset();
    set_idle();
    reset = 1'b0;
    bus.cpu_wr_op = 2'b00;
    bus.ext_req   = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      checks++; if (bus.mem_wr_op !== 2'b10) begin failures++; $display("FAIL reset_wr_op got=%b exp=10", bus.mem_wr_op); end
      checks++; if (bus.mem_rd_op !== 2'b10) begin failures++; $display("FAIL reset_rd_op got=%b exp=10", bus.mem_rd_op); end
      checks++; if (bus.ext_gnt !== 1'b0) begin failures++; $display("FAIL reset_gnt got=%b exp=0", bus.ext_gnt); end
      checks++; if (bus.cpu_stall !== 1'b0) begin failures++; $display("FAIL reset_stall got=%b exp=0", bus.cpu_stall); end
      tick();
    end
    set_idle();
    reset = 1'b1;
    @(negedge clk);
    checks++; if (bus.ext_rvalid !== 1'b0) begin failures++; $display("FAIL reset_rvalid got=%b exp=0", bus.ext_rvalid); end
    checks++; if (bus.ext_rdata !== 32'h0) begin failures++; $display("FAIL reset_rdata got=%h exp=0", bus.ext_rdata); end
    tick();
  endtask

  task automatic test_uncontended_read();
    set_idle();
    bus.ext_req   = 1'b1;
    bus.ext_we    = 1'b0;
    bus.ext_addr  = 32'h0000_0103;
    bus.mem_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    checks++; if (bus.ext_gnt !== 1'b1) begin failures++; $display("FAIL ur_gnt got=%b exp=1", bus.ext_gnt); end
    checks++; if (bus.mem_addr !== 32'h0000_0100) begin failures++; $display("FAIL ur_addr got=%h exp=00000100", bus.mem_addr); end
    checks++; if (bus.mem_rd_op !== 2'b00 || bus.mem_wr_op !== 2'b10) begin failures++; $display("FAIL ur_ops got=%b/%b exp=00/10", bus.mem_rd_op, bus.mem_wr_op); end
    checks++; if (bus.cpu_rdata !== 32'h0) begin failures++; $display("FAIL ur_cpu_rdata got=%h exp=0", bus.cpu_rdata); end
    tick();
    set_idle();
    @(negedge clk);
    checks++; if (bus.ext_rvalid !== 1'b1) begin failures++; $display("FAIL ur_rvalid got=%b exp=1", bus.ext_rvalid); end
    checks++; if (bus.ext_rdata !== 32'hDEAD_BEEF) begin failures++; $display("FAIL ur_rdata got=%h exp=deadbeef", bus.ext_rdata); end
    tick();
    @(negedge clk);
    checks++; if (bus.ext_rvalid !== 1'b0) begin failures++; $display("FAIL ur_rvalid_pulse got=%b exp=0", bus.ext_rvalid); end
    checks++; if (bus.ext_rdata !== 32'hDEAD_BEEF) begin failures++; $display("FAIL ur_rdata_hold got=%h exp=deadbeef", bus.ext_rdata); end
    tick();
  endtask

  task automatic test_passthrough();
    set_idle();
    bus.cpu_rd_op   = 2'b11;
    bus.cpu_rd_sign = 1'b1;
    bus.cpu_addr    = 32'h10;
    bus.cpu_wdata   = 32'h1234_5678;
    bus.mem_rdata   = 32'hCAFE_F00D;
    @(negedge clk);
    checks++; if (bus.mem_rd_op !== 2'b11 || bus.mem_wr_op !== 2'b10 || bus.mem_rd_sign !== 1'b1) begin failures++; $display("FAIL pt_ops got=%b/%b/%b exp=11/10/1", bus.mem_rd_op, bus.mem_wr_op, bus.mem_rd_sign); end
    checks++; if (bus.mem_addr !== 32'h10 || bus.mem_wdata !== 32'h1234_5678) begin failures++; $display("FAIL pt_addr got=%h/%h exp=00000010/12345678", bus.mem_addr, bus.mem_wdata); end
    checks++; if (bus.cpu_rdata !== 32'hCAFE_F00D) begin failures++; $display("FAIL pt_rdata got=%h exp=cafef00d", bus.cpu_rdata); end
    checks++; if (bus.cpu_stall !== 1'b0 || bus.ext_gnt !== 1'b0) begin failures++; $display("FAIL pt_stall got=%b/%b exp=0/0", bus.cpu_stall, bus.ext_gnt); end
    tick();
  endtask

  task automatic test_starvation();
    set_idle();
    bus.cpu_wr_op = 2'b00;
    bus.cpu_addr  = 32'h40;
    bus.cpu_wdata = 32'h1111_1111;
    bus.ext_req   = 1'b1;
    bus.ext_we    = 1'b1;
    bus.ext_addr  = 32'h0000_0206;
    bus.ext_wdata = 32'hA5A5_5A5A;
    for (int c = 0; c < MW; c++) begin
      @(negedge clk);
      checks++; if (bus.ext_gnt !== 1'b0 || bus.cpu_stall !== 1'b0) begin failures++; $display("FAIL sv_wait c=%0d got=%b/%b exp=0/0", c, bus.ext_gnt, bus.cpu_stall); end
      checks++; if (bus.mem_addr !== 32'h40) begin failures++; $display("FAIL sv_cpu_addr c=%0d got=%h exp=00000040", c, bus.mem_addr); end
      tick();
    end
    @(negedge clk);
    checks++; if (bus.ext_gnt !== 1'b1 || bus.cpu_stall !== 1'b1) begin failures++; $display("FAIL sv_force got=%b/%b exp=1/1", bus.ext_gnt, bus.cpu_stall); end
    checks++; if (bus.mem_wr_op !== 2'b00 || bus.mem_addr !== 32'h204 || bus.mem_wdata !== 32'hA5A5_5A5A) begin failures++; $display("FAIL sv_ext_bus got=%b/%h/%h exp=00/00000204/a5a55a5a", bus.mem_wr_op, bus.mem_addr, bus.mem_wdata); end
    tick();
    bus.ext_req = 1'b0;
    @(negedge clk);
    checks++; if (bus.ext_gnt !== 1'b0 || bus.cpu_stall !== 1'b0 || bus.mem_addr !== 32'h40) begin failures++; $display("FAIL sv_after got=%b/%b/%h exp=0/0/00000040", bus.ext_gnt, bus.cpu_stall, bus.mem_addr); end
    tick();
  endtask

  task automatic test_withdrawn();
    set_idle();
    bus.cpu_wr_op = 2'b00;
    bus.cpu_addr  = 32'h80;
    bus.ext_req   = 1'b1;
    bus.ext_we    = 1'b1;
    bus.ext_addr  = 32'h300;
    for (int c = 0; c < MW; c++) tick();
    bus.ext_req = 1'b0;
    @(negedge clk);
    checks++; if (bus.ext_gnt !== 1'b0 || bus.cpu_stall !== 1'b0) begin failures++; $display("FAIL wd_gnt got=%b/%b exp=0/0", bus.ext_gnt, bus.cpu_stall); end
    checks++; if (bus.mem_addr !== 32'h80 || bus.mem_wr_op !== 2'b00) begin failures++; $display("FAIL wd_cpu_bus got=%h/%b exp=00000080/00", bus.mem_addr, bus.mem_wr_op); end
    tick();
    checks++; if (dut.wait_cnt_q !== 4'd0) begin failures++; $display("FAIL wd_wait_cnt got=%0d exp=0", dut.wait_cnt_q); end
    // Back in NORMAL: a fresh contended request must lose, not be forced.
    bus.ext_req = 1'b1;
    @(negedge clk);
    checks++; if (bus.ext_gnt !== 1'b0 || bus.cpu_stall !== 1'b0) begin failures++; $display("FAIL wd_normal got=%b/%b exp=0/0", bus.ext_gnt, bus.cpu_stall); end
    tick();
    bus.ext_req = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid_force();
    set_idle();
    bus.cpu_wr_op = 2'b00;
    bus.ext_req   = 1'b1;
    bus.ext_we    = 1'b1;
    for (int c = 0; c < MW; c++) tick();
    reset = 1'b0;
    @(negedge clk);
    checks++; if (bus.ext_gnt !== 1'b0 || bus.cpu_stall !== 1'b0 || bus.mem_wr_op !== 2'b10) begin failures++; $display("FAIL rf_in_reset got=%b/%b/%b exp=0/0/10", bus.ext_gnt, bus.cpu_stall, bus.mem_wr_op); end
    tick();
    reset = 1'b1;
    @(negedge clk);
    checks++; if (bus.ext_gnt !== 1'b0 || bus.cpu_stall !== 1'b0) begin failures++; $display("FAIL rf_after got=%b/%b exp=0/0", bus.ext_gnt, bus.cpu_stall); end
    checks++; if (dut.wait_cnt_q !== 4'd0) begin failures++; $display("FAIL rf_wait_cnt got=%0d exp=0", dut.wait_cnt_q); end
    tick();
    set_idle();
    tick();
  endtask

  // Model: external wins when the CPU is idle, or once it has lost MW
  // contended cycles; that forced slot is consumed even if withdrawn.
  task automatic test_random();
    int lost = 0;
    logic exp_rvalid = 1'b0;
    logic [31:0] exp_rdata = '0;
    logic [1:0] ops [4] = '{2'b00, 2'b01, 2'b11, 2'b10};
    set_idle();
    for (int n = 0; n < 400; n++) begin
      logic active, forced, gnt, stall, cpu_own;
      logic [1:0] erd, ewr;
      logic [31:0] eaddr;
      bus.cpu_rd_op   = ($urandom_range(0, 9) < 5) ? ops[$urandom_range(0, 3)] : 2'b10;
      bus.cpu_wr_op   = ($urandom_range(0, 9) < 4) ? ops[$urandom_range(0, 3)] : 2'b10;
      bus.cpu_rd_sign = 1'($urandom);
      bus.cpu_addr    = $urandom;
      bus.cpu_wdata   = $urandom;
      bus.mem_rdata   = $urandom;
      if (!bus.ext_req && $urandom_range(0, 2) == 0) begin
        bus.ext_req   = 1'b1;
        bus.ext_we    = 1'($urandom);
        bus.ext_addr  = $urandom;
        bus.ext_wdata = $urandom;
      end else if (bus.ext_req && lost == MW && $urandom_range(0, 3) == 0) begin
        bus.ext_req = 1'b0;   // occasionally withdraw right at the forced slot
      end
      active  = (bus.cpu_rd_op != 2'b10) || (bus.cpu_wr_op != 2'b10);
      forced  = (lost == MW);
      gnt     = bus.ext_req && (forced || !active);
      stall   = gnt && active;
      cpu_own = !gnt && active;
      erd = 2'b10; ewr = 2'b10; eaddr = '0;
      if (gnt) begin
        erd = bus.ext_we ? 2'b10 : 2'b00;
        ewr = bus.ext_we ? 2'b00 : 2'b10;
        eaddr = {bus.ext_addr[31:2], 2'b00};
      end else if (cpu_own) begin
        erd = bus.cpu_rd_op; ewr = bus.cpu_wr_op; eaddr = bus.cpu_addr;
      end
      @(negedge clk);
      checks++; if (bus.ext_gnt !== gnt || bus.cpu_stall !== stall) begin failures++; $display("FAIL rnd_gnt n=%0d got=%b/%b exp=%b/%b", n, bus.ext_gnt, bus.cpu_stall, gnt, stall); end
      checks++; if (bus.mem_rd_op !== erd || bus.mem_wr_op !== ewr || bus.mem_addr !== eaddr) begin failures++; $display("FAIL rnd_bus n=%0d got=%b/%b/%h exp=%b/%b/%h", n, bus.mem_rd_op, bus.mem_wr_op, bus.mem_addr, erd, ewr, eaddr); end
      checks++; if (bus.cpu_rdata !== (cpu_own ? bus.mem_rdata : 32'h0)) begin failures++; $display("FAIL rnd_cpu_rdata n=%0d got=%h exp=%h", n, bus.cpu_rdata, cpu_own ? bus.mem_rdata : 32'h0); end
      checks++; if (bus.ext_rvalid !== exp_rvalid) begin failures++; $display("FAIL rnd_rvalid n=%0d got=%b exp=%b", n, bus.ext_rvalid, exp_rvalid); end
      if (exp_rvalid) begin
        checks++; if (bus.ext_rdata !== exp_rdata) begin failures++; $display("FAIL rnd_rdata n=%0d got=%h exp=%h", n, bus.ext_rdata, exp_rdata); end
      end
      exp_rvalid = gnt && !bus.ext_we;
      if (exp_rvalid) exp_rdata = bus.mem_rdata;
      if (forced || gnt || !bus.ext_req) lost = 0;
      else lost++;
      tick();
      if (gnt) bus.ext_req = 1'b0;
    end
    set_idle();
    tick();
  endtask

  initial begin
    set_idle();
    #1;
    test_reset();
    test_uncontended_read();
    test_passthrough();
    test_starvation();
    test_withdrawn();
    test_reset_mid_force();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Shares the single data-memory port between the pipeline's MEM stage and an external word-access requester, such as a UART loader or a debug/DMA engine. The CPU has priority. A starvation counter guarantees the external requester a slot within `MAX_WAIT` contended cycles by stalling the pipeline for one cycle. The block sits between the MEM stage's data-memory interface and the data memory, and drives the pipeline stall input.

## Interface
Parameters:
- `MAX_WAIT`, default 4: contended cycles an external request may lose before a forced grant; legal range 1..15.

Ports (reset is synchronous and active-low, on one clock):
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-low; sampled on `clk` rising edge.
- `cpu_rd_op` in 2: MEM-stage read op; 00 word, 01 half, 11 byte, 10 none.
- `cpu_wr_op` in 2: MEM-stage write op; same encoding.
- `cpu_rd_sign` in 1: sign-extend sub-word reads.
- `cpu_addr` in 32: MEM-stage byte address.
- `cpu_wdata` in 32: MEM-stage write data.
- `cpu_rdata` out 32: read data to MEM stage.
- `cpu_stall` out 1: holds the pipeline for the current cycle.
- `ext_req` in 1: external access request; held until `ext_gnt`.
- `ext_we` in 1: 1 = word write, 0 = word read.
- `ext_addr` in 32: external byte address; bits [1:0] ignored.
- `ext_wdata` in 32: external write data.
- `ext_gnt` out 1: external access performed this cycle.
- `ext_rdata` out 32: registered read data.
- `ext_rvalid` out 1: `ext_rdata` valid; one-cycle pulse.
- `mem_rd_op`, `mem_wr_op` out 2: to data memory.
- `mem_rd_sign` out 1: to data memory.
- `mem_addr` out 32: to data memory.
- `mem_wdata` out 32: to data memory.
- `mem_rdata` in 32: combinational read data from memory.

## Operation
CPU activity:
- `cpu_active` = (`cpu_rd_op` != 10) | (`cpu_wr_op` != 10).

Owner selection (combinational):
- The owner drives all `mem_*` outputs.
- The CPU owner passes its ops, sign, address and data straight through.
- The external owner drives word op 00 on the read or write port per `ext_we`. The other op is 10, `mem_rd_sign` = 0, and `mem_addr` = {`ext_addr`[31:2], 2'b00}.
- With no owner, both ops are 10 and address/data are 0.

`cpu_rdata`:
- Equals `mem_rdata` when the CPU is owner, otherwise 0.

States:
- **NORMAL**
  - `ext_req` & !`cpu_active`: external owner, `ext_gnt` = 1, no stall.
  - `ext_req` & `cpu_active`: CPU owner; `wait_cnt` increments. If `wait_cnt` == `MAX_WAIT`-1 before the increment, the next state is FORCE.
  - !`ext_req`: CPU owner if active, and `wait_cnt` clears to 0.
- **FORCE**
  - If `ext_req`: external owner, `ext_gnt` = 1, `cpu_stall` = `cpu_active`.
  - If !`ext_req` (request withdrawn): CPU owner, no grant, no stall.
  - In both cases the next state is NORMAL and `wait_cnt` = 0.

`wait_cnt`:
- 4 bits wide; clears on any `ext_gnt`. It never exceeds `MAX_WAIT`-1.

Stall rule:
- During a stall the CPU access is not issued; the pipeline re-presents it in the next cycle.
- `cpu_stall` is never 1 when `cpu_active` = 0, and never 1 in NORMAL.

External read data:
- On `ext_gnt` & !`ext_we`: `ext_rdata` <= `mem_rdata` and `ext_rvalid` <= 1 (next cycle).
- `ext_rvalid` is otherwise 0. `ext_rdata` holds its value until the next external read.

Reset (reset == 0 at a rising edge):
- State becomes NORMAL; `wait_cnt`, `ext_rdata` and `ext_rvalid` become 0.
- While `reset` is low, `ext_gnt` = 0, `cpu_stall` = 0, and `mem_rd_op` = `mem_wr_op` = 10, so no spurious writes occur.
- A reset in FORCE discards the pending forced grant.

## Timing
- CPU accesses have zero added latency; the memory path is combinational in both directions.
- An external uncontended access is granted in the same cycle `ext_req` is seen.
- External read data appears 1 cycle after `ext_gnt`.
- Worst-case external grant latency under continuous CPU traffic is `MAX_WAIT`+1 cycles from the rise of `ext_req`.
- Forced-grant throughput: at most 1 stall per `MAX_WAIT`+1 cycles.
- `ext_req` must stay high until `ext_gnt`. A new request may be presented in the cycle after `ext_gnt`.

## Test plan
- **Reset:** hold `reset` = 0 with `cpu_wr_op` = 00 and `ext_req` = 1. Required: `mem_wr_op` = 10, `ext_gnt` = 0, `cpu_stall` = 0, `ext_rvalid` = 0 after release.
- **Uncontended external read:** CPU idle (ops 10), `ext_req` = 1, `ext_we` = 0, `ext_addr` = 0x0000_0103, memory returns 0xDEAD_BEEF. Required: `ext_gnt` same cycle; `mem_addr` = 0x0000_0100, `mem_rd_op` = 00; next cycle `ext_rvalid` = 1, `ext_rdata` = 0xDEAD_BEEF.
- **CPU passthrough:** `cpu_rd_op` = 11, `cpu_rd_sign` = 1, `cpu_addr` = 0x10. Required: identical `mem_*` values, `cpu_rdata` = `mem_rdata`, no stall.
- **Starvation, MAX_WAIT = 4:** CPU issues word writes every cycle while `ext_req` = 1 from cycle 0. Required: `ext_gnt` = 0 in cycles 0-3; in cycle 4 `ext_gnt` = 1, `cpu_stall` = 1, `mem_wr_op` carries the external op; cycle 5 has CPU owner and no stall.
- **Withdrawn request:** enter FORCE, then drop `ext_req`. Required: no `ext_gnt`, no stall, `wait_cnt` = 0, return to NORMAL.
- **Reset mid-FORCE:** assert `reset` = 0 while in FORCE. Required: no grant after reset, `wait_cnt` = 0, `cpu_stall` stays 0.
